xenoa_semantic_norm: RTL and testbench
======================================

Name: xenoa_semantic_norm

Overview:
Parametrised, multi-type semantic standardization engine for the XENOA path.
- Accepts one raw sample per transaction (type index + value) over a valid/ready handshake.
- Looks the type up in a runtime-programmable descriptor table: key, unit, nominal min/max.
- Emits a standardized record: key, unit, bounds, value, deviation, severity, normalized value.
- Normalization uses a bit-serial divider, and every computation uses the descriptor snapshotted at accept time, so results are never computed from stale bounds.
- Sits between the XR-BUS frame extractor and downstream anomaly scoring.

Parameters:
NUM_TYPES, 8, number of descriptor table entries.
TYPE_W, 3, width of type index (clog2(NUM_TYPES)).
DATA_W, 32, width of value, bounds and deviation.
NORM_SCALE, 1000, full-scale normalized output (must be below 2^16).
NUM_W, DATA_W+16, dividend width; divider runs NUM_W cycles.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  sample valid.
in_ready  out  1  block can accept a sample.
in_type  in  TYPE_W  descriptor index.
in_value  in  DATA_W  raw unsigned sample.
cfg_we  in  1  descriptor write strobe.
cfg_idx  in  TYPE_W  descriptor index to write.
cfg_key  in  32  semantic key.
cfg_unit  in  8  unit code.
cfg_min  in  DATA_W  nominal minimum.
cfg_max  in  DATA_W  nominal maximum.
out_valid  out  1  record valid.
out_ready  in  1  downstream accepts record.
out_key  out  32  semantic key.
out_unit  out  8  unit code.
out_min  out  DATA_W  nominal min used.
out_max  out  DATA_W  nominal max used.
out_value  out  DATA_W  raw value.
out_deviation  out  DATA_W  distance outside the nominal band.
out_norm  out  16  normalized value, 0..NORM_SCALE.
out_severity  out  4  severity code.
out_err  out  1  descriptor invalid or unconfigured.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; in_ready=0 while rst=1, then 1 in IDLE.
  - Every descriptor entry's configured bit is cleared; FSM goes to IDLE.
  - Reset mid-transaction aborts the transaction; no record is emitted.
- Descriptor table:
  - A cfg_we write takes effect on the next edge and sets the entry's configured bit.
  - Writes are legal in any state.
  - The in-flight transaction uses its own snapshot, so a write to the same index in the accept cycle is not seen by that transaction.
- FSM: IDLE -> CALC -> DIV -> OUT -> IDLE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_value and snapshot the descriptor for in_type, then go to CALC.
  - CALC (1 cycle): compute span=max-min, deviation and severity.
    - err when the entry is unconfigured or min>=max.
    - If err: go to OUT with norm=0, deviation=0, severity=15, out_err=1.
    - Otherwise: load dividend=(clamp(value,min,max)-min)*NORM_SCALE (NUM_W bits, no overflow) and go to DIV.
  - DIV: restoring divide by span, 1 quotient bit per cycle, exactly NUM_W cycles, then go to OUT.
  - OUT: all out_* registered and stable, out_valid=1. Hold until out_ready=1, then go to IDLE with out_valid=0 on the next edge.
  - out_* keep their last values after the handshake.
- Latency from accept edge to out_valid: NUM_W+2 cycles (default 50). Error path: 2 cycles.
- Throughput: one transaction in flight; in_ready=0 outside IDLE.
- Deviation and severity:
  - min<=value<=max: deviation=0, severity=0.
  - value<min: deviation=min-value; severity=8 if deviation<=span, else 10.
  - value>max: deviation=value-max; severity=12 if deviation<=span, else 15.
- Normalization boundaries: value<=min gives norm 0; value>=max gives NORM_SCALE. Quotient truncates toward zero.

Test Plan:
- Nominal, in-band: type0 {key 1, unit 1, min 1100, max 1300}; value 1200 -> after 50 cycles out_norm=500, deviation=0, severity=0, out_err=0, out_key=1.
- Under and over band: value 1000 -> deviation 100, severity 8, norm 0. Value 1700 -> deviation 400 > span 200, severity 15, norm 1000.
- Invalid descriptors:
  - Unconfigured type5 -> out_valid 2 cycles after accept, out_err=1, severity 15, norm 0.
  - type3 with min=max=7 -> same error response.
- Backpressure: hold out_ready=0 for 20 cycles -> out_valid and all out_* stable, in_ready=0; release -> in_ready=1 the next cycle.
- Config race and truncation:
  - Rewrite type0 max 1300 -> 2100 in the accept cycle of value 1200 -> result uses 1300 (norm 500).
  - The next sample, value 1200 -> norm 100.
  - value 1101 with min 1100/max 1300 -> norm 5 (truncated).
- Reset mid-operation: assert rst at DIV cycle 20 -> out_valid=0, table cleared; a subsequent type0 sample returns out_err=1.

Source files
------------

// File: rtl/xenoa_semantic_norm.sv
// Semantic standardization engine: descriptor lookup, band deviation/severity,
// and bit-serial normalization of one raw sample at a time.
//
// state | meaning
// IDLE  | waiting for a sample, in_ready=1
// CALC  | span/deviation/severity from snapshot, load divider
// DIV   | restoring divide, one quotient bit per cycle
// OUT   | record valid, held until out_ready
module xenoa_semantic_norm #(
  parameter int NUM_TYPES  = 8,
  parameter int TYPE_W     = 3,
  parameter int DATA_W     = 32,
  parameter int NORM_SCALE = 1000,
  parameter int NUM_W      = DATA_W + 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TYPE_W-1:0] in_type,
  input  logic [DATA_W-1:0] in_value,
  input  logic              cfg_we,
  input  logic [TYPE_W-1:0] cfg_idx,
  input  logic [31:0]       cfg_key,
  input  logic [7:0]        cfg_unit,
  input  logic [DATA_W-1:0] cfg_min,
  input  logic [DATA_W-1:0] cfg_max,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_key,
  output logic [7:0]        out_unit,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_value,
  output logic [DATA_W-1:0] out_deviation,
  output logic [15:0]       out_norm,
  output logic [3:0]        out_severity,
  output logic              out_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(NUM_W + 1);
  localparam logic [NUM_W-1:0] SCALE = NUM_W'(NORM_SCALE);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DIV, S_OUT} state_t;
  state_t state, state_nxt;

  logic [31:0]          tbl_key  [NUM_TYPES];
  logic [7:0]           tbl_unit [NUM_TYPES];
  logic [DATA_W-1:0]    tbl_min  [NUM_TYPES];
  logic [DATA_W-1:0]    tbl_max  [NUM_TYPES];
  logic [NUM_TYPES-1:0] tbl_cfg;

  logic [31:0]       s_key;
  logic [7:0]        s_unit;
  logic [DATA_W-1:0] s_min, s_max, s_val;
  logic              s_cfg;

  logic [DATA_W-1:0] r_dev;
  logic [3:0]        r_sev;
  logic [NUM_W-1:0]  dvd;
  logic [DATA_W-1:0] rem;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic [DATA_W-1:0] span, dev_calc, clamp_off;
  logic [3:0]        sev_calc;
  logic              calc_err, under, over;
  logic [NUM_W-1:0]  dvd_init;
  logic [DATA_W:0]   rem_sh, rem_diff;
  logic              q_bit;
  logic [NUM_W-1:0]  quo_nxt;

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_OUT);
  assign busy      = (state != S_IDLE);

  // Descriptor table; reads for the snapshot see the pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tbl_cfg <= '0;
      for (int i = 0; i < NUM_TYPES; i++) begin
        tbl_key[i]  <= '0;
        tbl_unit[i] <= '0;
        tbl_min[i]  <= '0;
        tbl_max[i]  <= '0;
      end
    end else if (cfg_we) begin
      tbl_key[cfg_idx]  <= cfg_key;
      tbl_unit[cfg_idx] <= cfg_unit;
      tbl_min[cfg_idx]  <= cfg_min;
      tbl_max[cfg_idx]  <= cfg_max;
      tbl_cfg[cfg_idx]  <= 1'b1;
    end
  end

  always_comb begin
    span      = s_max - s_min;
    calc_err  = !s_cfg || (s_min >= s_max);
    under     = s_val < s_min;
    over      = s_val > s_max;
    dev_calc  = '0;
    sev_calc  = 4'd0;
    clamp_off = s_val - s_min;
    if (under) begin
      dev_calc  = s_min - s_val;
      sev_calc  = (dev_calc <= span) ? 4'd8 : 4'd10;
      clamp_off = '0;
    end else if (over) begin
      dev_calc  = s_val - s_max;
      sev_calc  = (dev_calc <= span) ? 4'd12 : 4'd15;
      clamp_off = span;
    end
    // clamp_off <= span < 2^DATA_W and SCALE < 2^16, so NUM_W bits cannot overflow
    dvd_init = {{(NUM_W-DATA_W){1'b0}}, clamp_off} * SCALE;
  end

  always_comb begin
    rem_sh   = {rem, dvd[NUM_W-1]};
    rem_diff = rem_sh - {1'b0, span};
    q_bit    = !rem_diff[DATA_W];
    quo_nxt  = {dvd[NUM_W-2:0], q_bit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CALC;
      S_CALC: state_nxt = calc_err ? S_OUT : S_DIV;
      S_DIV:  if (cnt == '0) state_nxt = S_OUT;
      S_OUT:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_key         <= '0;
      s_unit        <= '0;
      s_min         <= '0;
      s_max         <= '0;
      s_val         <= '0;
      s_cfg         <= 1'b0;
      r_dev         <= '0;
      r_sev         <= '0;
      dvd           <= '0;
      rem           <= '0;
      cnt           <= '0;
      out_key       <= '0;
      out_unit      <= '0;
      out_min       <= '0;
      out_max       <= '0;
      out_value     <= '0;
      out_deviation <= '0;
      out_norm      <= '0;
      out_severity  <= '0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            s_key  <= tbl_key[in_type];
            s_unit <= tbl_unit[in_type];
            s_min  <= tbl_min[in_type];
            s_max  <= tbl_max[in_type];
            s_cfg  <= tbl_cfg[in_type];
            s_val  <= in_value;
          end
        end
        S_CALC: begin
          if (calc_err) begin
            out_key       <= s_key;
            out_unit      <= s_unit;
            out_min       <= s_min;
            out_max       <= s_max;
            out_value     <= s_val;
            out_deviation <= '0;
            out_norm      <= '0;
            out_severity  <= 4'd15;
            out_err       <= 1'b1;
          end else begin
            r_dev <= dev_calc;
            r_sev <= sev_calc;
            dvd   <= dvd_init;
            rem   <= '0;
            cnt   <= CNT_W'(NUM_W - 1);
          end
        end
        S_DIV: begin
          dvd <= quo_nxt;
          rem <= q_bit ? rem_diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            out_key       <= s_key;
            out_unit      <= s_unit;
            out_min       <= s_min;
            out_max       <= s_max;
            out_value     <= s_val;
            out_deviation <= r_dev;
            out_norm      <= quo_nxt[15:0];
            out_severity  <= r_sev;
            out_err       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xenoa_semantic_norm.sv
// Bench for xenoa_semantic_norm: directed cases plus random traffic checked
// against an arithmetic model of the descriptor table and record rules.
module tb_xenoa_semantic_norm;

  localparam int SCALE = 1000;
  localparam int LAT   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_type = '0;
  logic [31:0] in_value = '0;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_idx = '0;
  logic [31:0] cfg_key = '0;
  logic [7:0]  cfg_unit = '0;
  logic [31:0] cfg_min = '0;
  logic [31:0] cfg_max = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_key;
  logic [7:0]  out_unit;
  logic [31:0] out_min, out_max, out_value, out_deviation;
  logic [15:0] out_norm;
  logic [3:0]  out_severity;
  logic        out_err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  xenoa_semantic_norm dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_value(in_value),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key), .cfg_unit(cfg_unit),
    .cfg_min(cfg_min), .cfg_max(cfg_max),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_key(out_key), .out_unit(out_unit), .out_min(out_min), .out_max(out_max),
    .out_value(out_value), .out_deviation(out_deviation), .out_norm(out_norm),
    .out_severity(out_severity), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // reference descriptor table
  logic [31:0] m_key [8];
  logic [7:0]  m_unit [8];
  longint      m_min [8];
  longint      m_max [8];
  bit          m_cfg [8];

  typedef struct {
    longint dev;
    longint norm;
    int     sev;
    bit     err;
    int     lat;
  } rec_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) begin
      m_key[i] = '0; m_unit[i] = '0; m_min[i] = 0; m_max[i] = 0; m_cfg[i] = 1'b0;
    end
  endfunction

  function automatic rec_t model(input int t, input longint v);
    rec_t r;
    longint mn = m_min[t];
    longint mx = m_max[t];
    longint span = mx - mn;
    r.dev = 0; r.norm = 0; r.sev = 0; r.err = 1'b0; r.lat = LAT;
    if (!m_cfg[t] || mn >= mx) begin
      r.err = 1'b1; r.sev = 15; r.lat = 2;
    end else if (v < mn) begin
      r.dev = mn - v;
      r.sev = (r.dev <= span) ? 8 : 10;
    end else if (v > mx) begin
      r.dev = v - mx;
      r.sev = (r.dev <= span) ? 12 : 15;
      r.norm = SCALE;
    end else begin
      r.norm = ((v - mn) * SCALE) / span;
    end
    return r;
  endfunction

  task automatic cfg_write(input int idx, input logic [31:0] key, input logic [7:0] unit,
                           input logic [31:0] mn, input logic [31:0] mx);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_key = key; cfg_unit = unit;
    cfg_min = mn; cfg_max = mx;
    m_key[idx] = key; m_unit[idx] = unit; m_min[idx] = longint'(mn);
    m_max[idx] = longint'(mx); m_cfg[idx] = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic run_txn(input int t, input logic [31:0] v, input int hold,
                         input bit race, input logic [31:0] race_max);
    rec_t e;
    int cyc;
    bit desc_known;
    logic [31:0] ek, emn, emx;
    logic [7:0]  eu;
    logic [15:0] hn;
    logic [31:0] hd;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    e = model(t, longint'(v));
    desc_known = m_cfg[t];
    ek = m_key[t]; eu = m_unit[t]; emn = m_min[t][31:0]; emx = m_max[t][31:0];
    in_valid = 1'b1; in_type = 3'(t); in_value = v;
    out_ready = (hold == 0);
    if (race) begin
      cfg_we = 1'b1; cfg_idx = 3'(t); cfg_key = m_key[t]; cfg_unit = m_unit[t];
      cfg_min = m_min[t][31:0]; cfg_max = race_max;
      m_max[t] = longint'(race_max); m_cfg[t] = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (!out_valid) begin
      chk("timeout", 0, 1);
      out_ready = 1'b1;
      return;
    end
    chk("latency", cyc, e.lat);
    chk("err", out_err, e.err);
    chk("sev", out_severity, e.sev);
    chk("dev", out_deviation, e.dev);
    chk("norm", out_norm, e.norm);
    chk("value", out_value, v);
    if (desc_known) begin
      chk("key", out_key, ek);
      chk("unit", out_unit, eu);
      chk("min", out_min, emn);
      chk("max", out_max, emx);
    end
    hn = out_norm; hd = out_deviation;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_norm", out_norm, e.norm);
        chk("hold_dev", out_deviation, e.dev);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_keep_norm", out_norm, hn);
    chk("post_keep_dev", out_deviation, hd);
  endtask

  initial begin
    model_clear();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_norm", out_norm, 0);
    chk("rst_sev", out_severity, 0);
    chk("rst_key", out_key, 0);
    chk("rst_err", out_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);

    cfg_write(0, 32'd1, 8'd1, 32'd1100, 32'd1300);
    run_txn(0, 1200, 0, 0, 0);   // 500
    run_txn(0, 1000, 0, 0, 0);   // dev 100 sev 8
    run_txn(0, 1700, 0, 0, 0);   // dev 400 sev 15
    run_txn(0, 1100, 0, 0, 0);
    run_txn(0, 1300, 0, 0, 0);
    run_txn(0, 1500, 0, 0, 0);   // dev == span -> 12
    run_txn(0, 1501, 0, 0, 0);
    run_txn(0, 900, 0, 0, 0);    // dev == span -> 8
    run_txn(0, 899, 0, 0, 0);
    run_txn(5, 1234, 0, 0, 0);   // unconfigured
    cfg_write(3, 32'hABCD, 8'd3, 32'd7, 32'd7);
    run_txn(3, 7, 0, 0, 0);
    run_txn(0, 1250, 20, 0, 0);  // backpressure
    run_txn(0, 1200, 0, 1, 32'd2100);
    run_txn(0, 1200, 0, 0, 0);   // 100
    cfg_write(0, 32'd1, 8'd1, 32'd1100, 32'd1300);
    run_txn(0, 1101, 0, 0, 0);   // 5 truncated

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        int idx = int'($urandom_range(0, 7));
        logic [31:0] mn, mx;
        if ($urandom_range(0, 9) == 0) begin
          mn = 32'd0; mx = 32'hFFFF_FFFF;
        end else begin
          mn = 32'($urandom_range(0, 100000));
          mx = ($urandom_range(0, 7) == 0) ? mn - 32'($urandom_range(0, 3))
                                           : mn + 32'($urandom_range(1, 50000));
        end
        cfg_write(idx, $urandom, 8'($urandom), mn, mx);
      end
      begin
        int t = int'($urandom_range(0, 7));
        logic [31:0] v = ($urandom_range(0, 7) == 0) ? $urandom
                                                     : 32'($urandom_range(0, 300000));
        run_txn(t, v, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0, 0, 0);
      end
    end

    cfg_write(0, 32'd1, 8'd1, 32'd1100, 32'd1300);
    @(negedge clk);
    in_valid = 1'b1; in_type = 3'd0; in_value = 32'd1200;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (21) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_norm", out_norm, 0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("after_rst_valid", out_valid, 0);
    end
    run_txn(0, 1200, 0, 0, 0);   // table cleared -> error

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
